sub_result_stage: RTL and testbench

//  Registered output stage directly downstream of the 8-bit subtract datapath (Y = A - B).

---
 rtl/sub_result_stage_if.sv | 25 ++
 rtl/sub_result_stage.sv | 85 ++++++++
 tb/tb_sub_result_stage.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/sub_result_stage_if.sv
// Handshake bundle between the subtractor, the result stage and the next ALU consumer.
// slave is the result-stage view; master is the producer/consumer view that drives it.
interface sub_result_stage_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] Y;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_Y;
  logic [3:0]       out_flags;

  modport slave (
    input  in_valid, A, B, Y, out_ready,
    output in_ready, out_valid, out_Y, out_flags
  );

  modport master (
    output in_valid, A, B, Y, out_ready,
    input  in_ready, out_valid, out_Y, out_flags
  );
endinterface

// File: rtl/sub_result_stage.sv
// Registered result stage after the A - B subtractor: derives {N,Z,C,V} and buffers {Y, flags} in a FIFO.
// Optional sticky C/V accumulator is built only when SUB_STICKY_FLAGS_EN is defined.
module sub_result_stage #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  sub_result_stage_if.slave     bus
`ifdef SUB_STICKY_FLAGS_EN
  ,
  input  logic                  sticky_clr,
  output logic [1:0]            sticky_flags
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = WIDTH + 4;

  logic [ENT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  logic       full;
  logic       empty;
  logic       push;
  logic       pop;
  logic [3:0] flags;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

  // Both handshakes depend only on registered occupancy, so out_ready never reaches in_ready.
  assign push = bus.in_valid && !full;
  assign pop  = bus.out_ready && !empty;

  always_comb begin
    flags    = '0;
    flags[3] = bus.Y[WIDTH-1];
    flags[2] = (bus.Y == '0);
    flags[1] = (bus.A < bus.B);
    flags[0] = (bus.A[WIDTH-1] != bus.B[WIDTH-1]) && (bus.Y[WIDTH-1] != bus.A[WIDTH-1]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; an entry is only observable once count covers it.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {bus.Y, flags};
  end

  assign bus.in_ready  = !full;
  assign bus.out_valid = !empty;
  assign bus.out_Y     = empty ? '0 : mem[rd_ptr][ENT_W-1:4];
  assign bus.out_flags = empty ? '0 : mem[rd_ptr][3:0];

`ifdef SUB_STICKY_FLAGS_EN
  // A set from this cycle's push overrides a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sticky_flags <= 2'b00;
    end else begin
      sticky_flags <= (sticky_clr ? 2'b00 : sticky_flags)
                    | ({2{push}} & {flags[1], flags[0]});
    end
  end
`endif

endmodule

// File: tb/tb_sub_result_stage.sv
// Self-checking bench for sub_result_stage: directed cases, randomized traffic against a queue model,
// and an asynchronous reset while full. Sticky checks are compiled in with SUB_STICKY_FLAGS_EN.
module tb_sub_result_stage;
  localparam int W = 8;
  localparam int D = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sub_result_stage_if #(.WIDTH(W)) bus ();

`ifdef SUB_STICKY_FLAGS_EN
  logic       sticky_clr;
  logic [1:0] sticky_flags;
`endif

  sub_result_stage #(.WIDTH(W), .DEPTH(D)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus.slave)
`ifdef SUB_STICKY_FLAGS_EN
    ,
    .sticky_clr   (sticky_clr),
    .sticky_flags (sticky_flags)
`endif
  );

  int tests = 0;
  int fails = 0;

  logic [11:0] q [$];
  logic [1:0]  sticky_m = 2'b00;
  logic        clr_in = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Flags from the arithmetic meaning of the subtraction rather than bit formulas.
  function automatic logic [3:0] ref_flags(input logic [7:0] a, input logic [7:0] b, input logic [7:0] y);
    int sa, sb, diff;
    sa   = (a > 127) ? int'(a) - 256 : int'(a);
    sb   = (b > 127) ? int'(b) - 256 : int'(b);
    diff = sa - sb;
    return {y > 8'd127, y == 8'd0, a < b, (diff > 127) || (diff < -128)};
  endfunction

  task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] y, input logic rdy, input logic clr);
    bus.in_valid  = v;
    bus.A         = a;
    bus.B         = b;
    bus.Y         = y;
    bus.out_ready = rdy;
    clr_in        = clr;
`ifdef SUB_STICKY_FLAGS_EN
    sticky_clr    = clr;
`endif
  endtask

  task automatic check_outputs(input string tag);
    logic [11:0] head;
    head = (q.size() != 0) ? q[0] : 12'h000;
    check({tag, ".out_valid"}, bus.out_valid, q.size() != 0);
    check({tag, ".in_ready"},  bus.in_ready,  q.size() < D);
    check({tag, ".out_Y"},     bus.out_Y,     head[11:4]);
    check({tag, ".out_flags"}, bus.out_flags, head[3:0]);
`ifdef SUB_STICKY_FLAGS_EN
    check({tag, ".sticky"},    sticky_flags,  sticky_m);
`endif
  endtask

  // One clock: check outputs mid-cycle, decide handshakes from the model, advance the model at the edge.
  task automatic tick(input string tag);
    logic        do_push, do_pop;
    logic [3:0]  f;
    logic [11:0] ent;
    @(negedge clk);
    check_outputs(tag);
    do_push = bus.in_valid && (q.size() < D);
    do_pop  = bus.out_ready && (q.size() != 0);
    f       = ref_flags(bus.A, bus.B, bus.Y);
    ent     = {bus.Y, f};
    @(posedge clk);
    if (do_pop) void'(q.pop_front());
    if (do_push) q.push_back(ent);
    sticky_m = (clr_in ? 2'b00 : sticky_m) | (do_push ? {f[1], f[0]} : 2'b00);
    #1;
  endtask

  task automatic step(input string tag, input logic v, input logic [7:0] a,
                      input logic [7:0] b, input logic rdy);
    drive(v, a, b, a - b, rdy, 1'b0);
    tick(tag);
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    #12;
    check_outputs("reset");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Basic pushes and their flags.
    step("t1_push", 1'b1, 8'd5, 8'd3, 1'b1);
    step("t1_out", 1'b0, 8'd0, 8'd0, 1'b1);
    step("t2_push", 1'b1, 8'd3, 8'd5, 1'b1);
    step("t2_out", 1'b0, 8'd0, 8'd0, 1'b1);
    step("t3_push_a", 1'b1, 8'h80, 8'h01, 1'b0);
    step("t3_push_b", 1'b1, 8'd7, 8'd7, 1'b0);
    step("t3_head_a", 1'b0, 8'd0, 8'd0, 1'b1);
    step("t3_head_b", 1'b0, 8'd0, 8'd0, 1'b1);
    step("t3_empty", 1'b0, 8'd0, 8'd0, 1'b1);

    // Fill with consumer stalled; the third push must be refused.
    step("t4_p1", 1'b1, 8'h11, 8'h01, 1'b0);
    step("t4_p2", 1'b1, 8'h22, 8'h03, 1'b0);
    step("t4_p3", 1'b1, 8'h33, 8'h50, 1'b0);
    step("t4_p3_full_pop", 1'b1, 8'h44, 8'h44, 1'b1);
    step("t4_drain1", 1'b0, 8'd0, 8'd0, 1'b1);
    step("t4_drain2", 1'b0, 8'd0, 8'd0, 1'b1);
    check("t4_drained", q.size(), 0);

    // Single entry with concurrent push/pop exercises pointer wrap.
    step("t5_prime", 1'b1, 8'h01, 8'h02, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step("t5_pp", 1'b1, 8'(8'h40 + i * 37), 8'(i * 91), 1'b1);
      check("t5_count", q.size(), 1);
    end
    step("t5_drain", 1'b0, 8'd0, 8'd0, 1'b1);

    // Randomized traffic with occasional sticky clears.
    for (int i = 0; i < 300; i++) begin
      logic [7:0] a, b;
      a = 8'($urandom);
      b = 8'($urandom);
      drive(($urandom_range(0, 3) != 0), a, b, a - b, ($urandom_range(0, 2) != 0),
            ($urandom_range(0, 9) == 0));
      tick("rand");
    end

    // Async reset while full, asserted away from the clock edge.
    step("t6_fill1", 1'b1, 8'h00, 8'h01, 1'b0);
    step("t6_fill2", 1'b1, 8'h80, 8'h7F, 1'b0);
    check("t6_full", bus.in_ready, 1'b0);
    drive(1'b1, 8'h05, 8'h09, 8'hFC, 1'b1, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    q.delete();
    sticky_m = 2'b00;
    check_outputs("t6_async_rst");
    @(negedge clk);
    check_outputs("t6_held_rst");
    rst = 1'b0;
    drive(1'b0, 8'd0, 8'd0, 8'd0, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    step("t6_after", 1'b1, 8'h10, 8'h20, 1'b1);
    step("t6_after_out", 1'b0, 8'd0, 8'd0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
